fifo_rd_stream: RTL and testbench

//  Read-side adapter directly downstream of the single-clock fifo. Drives the fifo's
//  rd_en, captures its 1-cycle-latency rd_data and presents a registered valid/ready

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_skid2.sv | 72 +++++++
 rtl/fifo_rd_stream.sv | 80 ++++++++
 tb/tb_fifo_rd_stream.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared fifo definitions: occupancy encoding and the read-issue helper.
package fifo_pkg;

    localparam int unsigned OCC_W = 2;

    typedef logic [OCC_W-1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_TWO   = 2'd2;

    // A read may be issued when words held plus words returning, less this cycle's pop, stays below two.
    // A pop only happens with occ >= 1, so the subtraction never underflows.
    function automatic logic can_issue(input occ_t occ, input logic inflight, input logic pop);
        logic [2:0] load;
        load = 3'(occ) + 3'(inflight) - 3'(pop);
        return (load < 3'd2);
    endfunction

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry head/skid holding register with push, pop and clear.
// Pop is applied before push, so a push lands in the slot freed by a same-cycle pop.
module fifo_skid2
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  valid,
    output occ_t                  occ
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    occ_t                  occ_q, occ_d;
    occ_t                  occ_left;
    logic                  valid_q;

    // State registers; valid is kept as its own flop so the stream valid is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            skid_q  <= '0;
            occ_q   <= OCC_EMPTY;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            skid_q  <= skid_d;
            occ_q   <= occ_d;
            valid_q <= (occ_d != OCC_EMPTY);
        end
    end

    // Next-state: clear wins; otherwise pop shifts skid to head, then push fills the next free slot.
    always_comb begin
        head_d   = head_q;
        skid_d   = skid_q;
        occ_d    = occ_q;
        occ_left = occ_q;
        if (clear) begin
            occ_d = OCC_EMPTY;
        end else begin
            if (pop && (occ_q != OCC_EMPTY)) begin
                occ_left = occ_q - OCC_ONE;
                if (occ_q == OCC_TWO) begin
                    head_d = skid_q;
                end
            end
            if (push) begin
                if (occ_left == OCC_EMPTY) begin
                    head_d = push_data;
                end else begin
                    skid_d = push_data;
                end
                occ_d = occ_left + OCC_ONE;
            end else begin
                occ_d = occ_left;
            end
        end
    end

    assign head  = head_q;
    assign valid = valid_q;
    assign occ   = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter behind the single-clock fifo: issues rd_en, captures the
// one-cycle-latency read data and presents a registered valid/ready stream.
// Optional feature macro: FIFO_RD_STREAM_STATS_EN adds the beat_cnt_o counter port.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    input  logic                  flush_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [31:0]           beat_cnt_o
`endif
);

    localparam int unsigned CNT_W = 32;

    logic inflight_q;
    logic pop;
    logic push;
    occ_t occ;

    assign pop  = m_valid_o & m_ready_i;
    // A word returning during a flush is dropped.
    assign push = inflight_q & ~flush_i;

    // Issue combinationally from m_ready_i so a drained slot is refilled without a bubble.
    assign fifo_rd_en_o = rst_n & ~fifo_empty_i & ~flush_i & can_issue(occ, inflight_q, pop);

    fifo_skid2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush_i),
        .push      (push),
        .push_data (fifo_data_i),
        .pop       (pop),
        .head      (m_data_o),
        .valid     (m_valid_o),
        .occ       (occ)
    );

    // Track the read whose data appears on fifo_data_i next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= fifo_rd_en_o;
        end
    end

`ifdef FIFO_RD_STREAM_STATS_EN
    logic [CNT_W-1:0] beat_cnt_q;

    // Count accepted beats; wraps naturally, untouched by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
        end else if (pop) begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
        end
    end

    assign beat_cnt_o = beat_cnt_q;
`endif

    // Words held plus words returning can never exceed the two buffer slots.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (3'(occ) + 3'(inflight_q)) <= 3'd2);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural 1-cycle-latency fifo and
// an in-order scoreboard. Compile with FIFO_RD_STREAM_STATS_EN to cover the counter.
module tb_fifo_rd_stream;
    import fifo_pkg::*;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_empty_i = 1'b1;
    logic          fifo_rd_en_o;
    logic [DW-1:0] fifo_data_i = '0;
    logic          flush_i = 1'b0;
    logic          m_valid_o;
    logic          m_ready_i = 1'b0;
    logic [DW-1:0] m_data_o;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0]   beat_cnt_o;
`endif

    always #5 clk = ~clk;

    fifo_rd_stream #(
        .DATA_WIDTH(DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rd_en_o (fifo_rd_en_o),
        .fifo_data_i  (fifo_data_i),
        .flush_i      (flush_i),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .m_data_o     (m_data_o)
`ifdef FIFO_RD_STREAM_STATS_EN
        ,
        .beat_cnt_o   (beat_cnt_o)
`endif
    );

    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    int            compared = 0;
    int            mismatched = 0;
    int            pops = 0;
    int            rd_cnt = 0;
    bit            last_rd = 1'b0;
    bit            sb_en = 1'b1;
    int            pops_before = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Put n consecutive words into the fifo model and the expected stream.
    task automatic load(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            fq.push_back(base + DW'(i));
            exp_q.push_back(base + DW'(i));
        end
        fifo_empty_i = (fq.size() == 0);
    endtask

    // One clock: sample handshake and rd_en at the falling edge, advance the fifo model after the rising edge.
    task automatic tick();
        logic          rd;
        logic          pop;
        logic [DW-1:0] d;
        logic [DW-1:0] e;
        @(negedge clk);
        rd  = fifo_rd_en_o;
        pop = m_valid_o & m_ready_i;
        d   = m_data_o;
        @(posedge clk);
        #1;
        last_rd = rd;
        if (rd) begin
            rd_cnt++;
            if (fq.size() > 0) fifo_data_i = fq.pop_front();
        end
        fifo_empty_i = (fq.size() == 0);
        if (pop) begin
            pops++;
            if (sb_en) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $error("FAIL sb_extra: observed 0x%0h expected no beat", d);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_order", 64'(d), 64'(e));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1;
        check("rst_valid", 64'(m_valid_o), 64'd0);
        check("rst_data", 64'(m_data_o), 64'd0);
        check("rst_rd_en", 64'(fifo_rd_en_o), 64'd0);
`ifdef FIFO_RD_STREAM_STATS_EN
        check("rst_cnt", 64'(beat_cnt_o), 64'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("idle_valid", 64'(m_valid_o), 64'd0);

        // Streaming 0x1..0x8 with the consumer always ready
        m_ready_i = 1'b1;
        load(8, 32'h1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("stream_rd", 64'(last_rd), 64'(k <= 8));
            check("stream_valid", 64'(m_valid_o), 64'((k >= 2) && (k <= 9)));
            if ((k >= 2) && (k <= 9)) check("stream_data", 64'(m_data_o), 64'(k - 1));
        end

        // Back-pressure: two reads fill the buffer, head holds 0x1
        m_ready_i = 1'b0;
        rd_cnt = 0;
        load(8, 32'h1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k >= 2) begin
                check("bp_valid", 64'(m_valid_o), 64'd1);
                check("bp_data", 64'(m_data_o), 64'h1);
            end
        end
        check("bp_reads", 64'(rd_cnt), 64'd2);
        m_ready_i = 1'b1;
        repeat (12) tick();
        check("bp_drained", 64'(exp_q.size()), 64'd0);
        check("bp_idle", 64'(m_valid_o), 64'd0);

        // Alternating ready over 16 words
        load(16, 32'h10);
        for (int k = 0; k < 40; k++) begin
            m_ready_i = (k % 2 == 0);
            tick();
        end
        m_ready_i = 1'b1;
        repeat (4) tick();
        check("alt_drained", 64'(exp_q.size()), 64'd0);

        // Flush with the buffer at its limit (one held, one returning)
        m_ready_i = 1'b0;
        load(8, 32'h21);
        tick();
        tick();
        check("pre_flush_valid", 64'(m_valid_o), 64'd1);
        check("pre_flush_data", 64'(m_data_o), 64'h21);
        flush_i = 1'b1;
        tick();
        check("flush_valid", 64'(m_valid_o), 64'd0);
        #1;
        check("flush_no_rd", 64'(fifo_rd_en_o), 64'd0);
        tick();
        check("flush_hold_valid", 64'(m_valid_o), 64'd0);
        flush_i = 1'b0;
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        m_ready_i = 1'b1;
        tick();
        check("post_flush_lat", 64'(m_valid_o), 64'd0);
        tick();
        check("post_flush_valid", 64'(m_valid_o), 64'd1);
        check("post_flush_data", 64'(m_data_o), 64'h23);
        repeat (10) tick();
        check("flush_drained", 64'(exp_q.size()), 64'd0);

`ifdef FIFO_RD_STREAM_STATS_EN
        // Beat counter: 10 more pops, then a flush that must not disturb it
        check("stats_sync", 64'(beat_cnt_o), 64'(pops));
        pops_before = pops;
        load(10, 32'h40);
        repeat (14) tick();
        check("stats_10", 64'(beat_cnt_o), 64'(pops_before + 10));
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        tick();
        check("stats_flush", 64'(beat_cnt_o), 64'(pops_before + 10));
`endif

        // Asynchronous reset in the middle of a stream
        load(6, 32'h50);
        tick();
        tick();
        tick();
        check("mid_valid_pre", 64'(m_valid_o), 64'd1);
        sb_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(m_valid_o), 64'd0);
        check("mid_rst_rd_en", 64'(fifo_rd_en_o), 64'd0);
        check("mid_rst_data", 64'(m_data_o), 64'd0);
        tick();
        check("mid_rst_no_rd", 64'(last_rd), 64'd0);
        rst_n = 1'b1;
        tick();
        check("mid_rel_valid", 64'(m_valid_o), 64'd0);
`ifdef FIFO_RD_STREAM_STATS_EN
        check("mid_rel_cnt", 64'(beat_cnt_o), 64'd0);
`endif
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
